// File: rtl/mem_bridge_if.sv
// CPU-side and physical-memory-side signals of the memory bridge.
// slave: the bridge itself; master: the CPU plus physical memory around it.
interface mem_bridge_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ifetch;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        mem_err;

    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_wdata;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_ifetch, mem_funct3, mem_wdata,
        output mem_rdata, mem_resp, mem_err,
        output pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_ifetch, mem_funct3, mem_wdata,
        input  mem_rdata, mem_resp, mem_err,
        input  pmem_address, pmem_read, pmem_write, pmem_wmask, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_bridge.sv
// Purpose: translates CPU byte/half/word accesses into word-aligned physical memory requests.
// Latency: misaligned -> mem_resp next cycle; otherwise pmem request next cycle, mem_resp one cycle after pmem_resp.
// Backpressure: CPU holds its request until mem_resp; pmem request held until pmem_resp or MAX_WAIT-cycle timeout.
module mem_bridge #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_bridge_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [10:0] WAIT_LIMIT = 11'(MAX_WAIT);

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic        ifetch;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [1:0] size_of(input logic ifetch, input logic [2:0] f3);
        if (ifetch) return SZ_W;
        case (f3)
            3'b000, 3'b100: return SZ_B;
            3'b001, 3'b101: return SZ_H;
            default:        return SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == SZ_W) && (off != 2'b00)) || ((sz == SZ_H) && off[0]);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wdata);
        case (sz)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] sz, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (sz)
            SZ_B:    return {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    logic [1:0]  state;
    req_t        req;
    logic [9:0]  wait_cnt;
    logic        mem_resp;
    logic        mem_err;
    logic [31:0] mem_rdata;

    logic [1:0]  in_sz;
    logic        in_mis;
    logic [1:0]  req_sz;
    logic        req_sgn;
    logic        wait_expired;

    assign in_sz        = size_of(bus.mem_ifetch, bus.mem_funct3);
    assign in_mis       = misaligned(in_sz, bus.mem_address[1:0]);
    assign req_sz       = size_of(req.ifetch, req.funct3);
    assign req_sgn      = ~req.ifetch & ~req.funct3[2];
    assign wait_expired = ({1'b0, wait_cnt} + 11'd1) == WAIT_LIMIT;

    // pmem side is decoded purely from registered state and the captured request.
    assign bus.pmem_read    = (state == READ);
    assign bus.pmem_write   = (state == WRITE);
    assign bus.pmem_address = {req.addr[31:2], 2'b00};
    assign bus.pmem_wmask   = (state == WRITE) ? lane_mask(req_sz, req.addr[1:0]) : 4'b0000;
    assign bus.pmem_wdata   = lane_data(req_sz, req.wdata);

    assign bus.mem_resp  = mem_resp;
    assign bus.mem_err   = mem_err;
    assign bus.mem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            wait_cnt  <= '0;
            mem_resp  <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_resp <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        req <= '{addr: bus.mem_address, funct3: bus.mem_funct3,
                                 ifetch: bus.mem_ifetch, wdata: bus.mem_wdata};
                        wait_cnt <= '0;
                        if (in_mis) begin
                            state     <= RESP;
                            mem_resp  <= 1'b1;
                            mem_err   <= 1'b1;
                            mem_rdata <= '0;
                        end else if (bus.mem_read) begin
                            state <= READ;
                        end else begin
                            state <= WRITE;
                        end
                    end
                end
                READ, WRITE: begin
                    if (bus.pmem_resp) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                        if (state == READ)
                            mem_rdata <= extract(req_sz, req_sgn, req.addr[1:0], bus.pmem_rdata);
                    end else if (wait_expired) begin
                        state     <= RESP;
                        mem_resp  <= 1'b1;
                        mem_err   <= 1'b1;
                        mem_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                // Single-cycle response; the CPU's still-high request is deliberately not looked at here.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bridge.sv
// Randomised scoreboard bench for mem_bridge with a behavioural memory responder.
`timescale 1ns/1ps
module tb_mem_bridge;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bridge_if bus();

    mem_bridge #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [3:0] wmask; logic [31:0] wdata; } preq_t;

    resp_t       exp_q[$];
    preq_t       pexp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;
    logic        stale_req = 1'b0;
    logic [31:0] model_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic ifetch, input logic [2:0] f3);
        if (ifetch) return 4;
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic ifetch,
                                               input logic [2:0] f3, input logic [31:0] word);
        int     sz;
        int     off;
        longint v;
        sz  = acc_size(ifetch, f3);
        off = int'(addr[1:0]);
        v   = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if (sz < 4 && !ifetch && (f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_mask(input int sz, input logic [31:0] addr);
        int mi;
        mi = ((1 << sz) - 1) << int'(addr[1:0]);
        return mi[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wdata);
        if (sz == 1) return 32'(wdata[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(wdata[15:0]) * 32'h0001_0001;
        return wdata;
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr, input logic ifetch,
                          input logic [2:0] f3, input logic [31:0] wdata, input int delay,
                          input logic [31:0] word);
        int    sz;
        bit    mis;
        bit    tmo;
        int    lat_exp;
        int    k;
        resp_t e;
        preq_t p;
        sz  = acc_size(ifetch, f3);
        mis = (int'(addr[1:0]) % sz) != 0;
        tmo = !mis && (delay >= MAX_WAIT);
        if (mis || tmo) e.rdata = '0;
        else if (rd)    e.rdata = model_load(addr, ifetch, f3, word);
        else            e.rdata = model_last;
        e.err      = mis || tmo;
        model_last = e.rdata;
        exp_q.push_back(e);
        if (!mis) begin
            p.wr    = !rd;
            p.addr  = {addr[31:2], 2'b00};
            p.wmask = rd ? 4'b0000 : model_mask(sz, addr);
            p.wdata = model_wdata(sz, wdata);
            pexp_q.push_back(p);
        end
        lat_exp = mis ? 1 : (tmo ? MAX_WAIT + 1 : delay + 2);

        @(posedge clk); #1;
        cur_delay       = delay;
        cur_rdata       = word;
        bus.mem_address = addr;
        bus.mem_ifetch  = ifetch;
        bus.mem_funct3  = f3;
        bus.mem_wdata   = wdata;
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mem_resp && k < 40);
        check("resp_seen", 32'(bus.mem_resp), 32'd1);
        check("latency", k - 1, lat_exp);
        check("pmem_dropped_at_resp", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        @(posedge clk); #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_resp",   32'(bus.mem_resp),   32'd0);
        check("rst_mem_err",    32'(bus.mem_err),    32'd0);
        check("rst_pmem_read",  32'(bus.pmem_read),  32'd0);
        check("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        check("rst_pmem_wmask", 32'(bus.pmem_wmask), 32'd0);
        check("rst_mem_rdata",  bus.mem_rdata,       32'd0);
    endtask

    task automatic reset_mid_read();
        preq_t p;
        int    k;
        p.wr = 1'b0; p.addr = 32'h0000_0500; p.wmask = 4'b0000; p.wdata = '0;
        pexp_q.push_back(p);
        @(posedge clk); #1;
        cur_delay       = 100;
        bus.mem_address = 32'h0000_0500;
        bus.mem_ifetch  = 1'b0;
        bus.mem_funct3  = 3'b010;
        bus.mem_read    = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.pmem_read && k < 10);
        check("rst_test_pmem_read_seen", 32'(bus.pmem_read), 32'd1);
        @(posedge clk); #1;
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        stale_req  = 1'b1;
        model_last = '0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        stale_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // ---------------- physical memory responder ----------------
    initial begin : responder
        int    cnt;
        bit    active;
        preq_t p;
        cnt = 0;
        active = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            bus.pmem_resp = 1'b0;
            if (rst) begin
                cnt = 0;
                active = 0;
                continue;
            end
            if (!bus.pmem_write) check("wmask_zero_without_write", 32'(bus.pmem_wmask), 32'd0);
            if (bus.pmem_read || bus.pmem_write) begin
                if (!active) begin
                    active = 1;
                    cnt = 0;
                    if (pexp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL pmem_unexpected: got request at 0x%08h, expected none", bus.pmem_address);
                    end else begin
                        p = pexp_q.pop_front();
                        check("pmem_write", 32'(bus.pmem_write), 32'(p.wr));
                        check("pmem_read", 32'(bus.pmem_read), 32'(!p.wr));
                        check("pmem_address", bus.pmem_address, p.addr);
                        if (p.wr) begin
                            check("pmem_wmask", 32'(bus.pmem_wmask), 32'(p.wmask));
                            check("pmem_wdata", bus.pmem_wdata, p.wdata);
                        end
                    end
                end
                if (cnt == cur_delay) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = cur_rdata;
                end
                cnt++;
            end else begin
                active = 0;
                cnt = 0;
            end
            if (stale_req) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        logic [31:0] last_exp;
        resp_t       e;
        last_exp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp = '0;
            end else if (bus.mem_resp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got mem_resp=1, expected no response");
                end else begin
                    e = exp_q.pop_front();
                    check("mem_rdata", bus.mem_rdata, e.rdata);
                    check("mem_err", 32'(bus.mem_err), 32'(e.err));
                    last_exp = e.rdata;
                end
            end else begin
                check("rdata_hold", bus.mem_rdata, last_exp);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int        sel;
        logic      rd;
        logic      wr;
        int        dly;
        bus.mem_address = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_ifetch  = 1'b0;
        bus.mem_funct3  = 3'b000;
        bus.mem_wdata   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        do_txn(1'b1, 1'b0, 32'h0000_0060, 1'b1, 3'b000, 32'h0, 3, 32'h00A0_0093);   // fetch
        do_txn(1'b1, 1'b0, 32'h0000_0103, 1'b0, 3'b000, 32'h0, 1, 32'h80FF_1234);   // lb
        do_txn(1'b1, 1'b0, 32'h0000_0103, 1'b0, 3'b100, 32'h0, 0, 32'h80FF_1234);   // lbu
        do_txn(1'b0, 1'b1, 32'h0000_0206, 1'b0, 3'b001, 32'h0000_BEEF, 0, 32'h0);   // sh
        do_txn(1'b1, 1'b0, 32'h0000_0302, 1'b0, 3'b010, 32'h0, 0, 32'h1111_1111);   // misaligned lw
        do_txn(1'b1, 1'b0, 32'h0000_0401, 1'b0, 3'b101, 32'h0, 0, 32'h1111_1111);   // misaligned lhu
        do_txn(1'b1, 1'b0, 32'h0000_0400, 1'b0, 3'b010, 32'h0, MAX_WAIT + 2, 32'h0); // timeout
        do_txn(1'b1, 1'b1, 32'h0000_0482, 1'b0, 3'b001, 32'hFFFF_FFFF, 2, 32'h8001_7FFE); // read wins
        do_txn(1'b1, 1'b0, 32'h0000_0488, 1'b0, 3'b111, 32'h0, 0, 32'hCAFE_F00D);   // undefined -> w
        reset_mid_read();
        do_txn(1'b1, 1'b0, 32'h0000_0504, 1'b0, 3'b010, 32'h0, 1, 32'h1234_5678);

        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom % 8);
            rd  = (sel < 4) || (sel == 7);
            wr  = (sel >= 4);
            dly = ($urandom % 10 == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            do_txn(rd, wr, $urandom, ($urandom % 8) == 0, 3'($urandom % 8), $urandom, dly, $urandom);
            repeat ($urandom % 3) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        check("pending_responses", exp_q.size(), 32'd0);
        check("pending_pmem_requests", pexp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
